// File: rtl/psram_pkg.sv
// Shared types and helpers for the multi-port PSRAM controller.
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RECOVER
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Byte writes put the same byte on both halves; UB/LB pick the lane.
    function automatic logic [15:0] rep_byte(input logic [7:0] b);
        return {b, b};
    endfunction

    // Width of a port index; never zero so a single-port build still has a bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psram_port_arbiter.sv
// Combinational grant selection: fixed priority or round-robin after ptr.
module psram_port_arbiter
    import psram_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int ARB_MODE  = ARB_FIXED,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx
);

    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    logic                 found;
    int unsigned          pos;
    logic [NUM_PORTS-1:0] req_rot;

    // Walk the ports in search order and take the first one requesting.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        req_rot = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == ARB_RR)
                pos = (32'(ptr) + k + 1) % NUM_PORTS;
            else
                pos = k;
            req_rot = req >> pos;
            if (!found && req_rot[0]) begin
                found = 1'b1;
                grant = ONE << pos;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/psram_multiport_ctrl.sv
// Arbitrates NUM_PORTS byte requesters onto one asynchronous 16-bit PSRAM.
module psram_multiport_ctrl #(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_W      = 24,
    parameter int WAIT_CYCLES = 3,
    parameter int RECOVERY    = 1,
    parameter int ARB_RR      = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*8-1:0]      wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS-1:0]        done,
    output logic [7:0]                  rdata,
    output logic                        busy,
    output logic                        mem_oe_n,
    output logic                        mem_we_n,
    output logic                        ram_cs_n,
    output logic                        ram_ub_n,
    output logic                        ram_lb_n,
    output logic                        mem_adv,
    output logic                        mem_clk,
    output logic                        ram_cre,
    output logic [ADDR_W-2:0]           mem_adr,
    output logic [15:0]                 mem_db_o,
    output logic                        mem_db_oe,
    input  logic [15:0]                 mem_db_i
);
    import psram_pkg::*;

    localparam int IDX_W   = idx_width(NUM_PORTS);
    localparam int CNT_MAX = (WAIT_CYCLES > RECOVERY) ? WAIT_CYCLES : RECOVERY;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]    sel_q, sel_d;
    logic                    wr_q, wr_d;
    logic                    a0_q, a0_d;
    logic [7:0]              wd_q, wd_d;
    logic [ADDR_W-2:0]       adr_q, adr_d;
    logic                    cs_q, cs_d, oe_q, oe_d, wen_q, wen_d;
    logic                    ub_q, ub_d, lb_q, lb_d, dboe_q, dboe_d;
    logic [NUM_PORTS-1:0]    ack_q, ack_d, done_q, done_d;
    logic [7:0]              rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]    grant;
    logic [IDX_W-1:0]        gidx;
    logic [ADDR_W-1:0]       addr_arr  [NUM_PORTS];
    logic [7:0]              wdata_arr [NUM_PORTS];
    logic [ADDR_W-1:0]       g_addr;
    logic                    g_we;
    logic [7:0]              g_wdata;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = wdata[i*8 +: 8];
    end

    psram_port_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  ((ARB_RR != 0) ? psram_pkg::ARB_RR : psram_pkg::ARB_FIXED),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    assign g_addr  = addr_arr[gidx];
    assign g_we    = we[gidx];
    assign g_wdata = wdata_arr[gidx];

    // Next-state and next-output logic; bus controls are registered so they change on the edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        a0_d    = a0_q;
        wd_d    = wd_q;
        adr_d   = adr_q;
        cs_d    = cs_q;
        oe_d    = oe_q;
        wen_d   = wen_q;
        ub_d    = ub_q;
        lb_d    = lb_q;
        dboe_d  = dboe_q;
        ack_d   = '0;
        done_d  = '0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                    ptr_d   = gidx;
                    sel_d   = grant;
                    wr_d    = g_we;
                    a0_d    = g_addr[0];
                    wd_d    = g_wdata;
                    adr_d   = g_addr[ADDR_W-1:1];
                    cs_d    = 1'b0;
                    ub_d    = g_addr[0];
                    lb_d    = ~g_addr[0];
                    oe_d    = g_we;
                    wen_d   = ~g_we;
                    dboe_d  = g_we;
                    ack_d   = grant;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    if (!wr_q)
                        rdata_d = a0_q ? mem_db_i[7:0] : mem_db_i[15:8];
                    cs_d    = 1'b1;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    dboe_d  = 1'b0;
                    done_d  = sel_q;
                    cnt_d   = '0;
                    state_d = (RECOVERY > 0) ? ST_RECOVER : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == CNT_W'(RECOVERY - 1))
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
            sel_q   <= '0;
            wr_q    <= 1'b0;
            a0_q    <= 1'b0;
            wd_q    <= '0;
            adr_q   <= '0;
            cs_q    <= 1'b1;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            dboe_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            a0_q    <= a0_d;
            wd_q    <= wd_d;
            adr_q   <= adr_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            wen_q   <= wen_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            dboe_q  <= dboe_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign ram_cs_n  = cs_q;
    assign mem_oe_n  = oe_q;
    assign mem_we_n  = wen_q;
    assign ram_ub_n  = ub_q;
    assign ram_lb_n  = lb_q;
    assign mem_adr   = adr_q;
    assign mem_db_o  = rep_byte(wd_q);
    assign mem_db_oe = dboe_q;
    assign mem_adv   = 1'b0;
    assign mem_clk   = 1'b0;
    assign ram_cre   = 1'b0;

endmodule

// File: tb/tb_psram_multiport_ctrl.sv
// Directed bench: four controller builds (default, round-robin, no recovery, single wait) share stimulus.
module tb_psram_multiport_ctrl;

    localparam int NP = 3;
    localparam int AW = 24;
    localparam int NI = 4;

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NP-1:0]      req, we;
    logic [NP*AW-1:0]   addr;
    logic [NP*8-1:0]    wdata;
    logic [15:0]        db_i;

    logic [NP-1:0] ack_v [NI];
    logic [NP-1:0] done_v [NI];
    logic [7:0]    rdata_v [NI];
    logic          busy_v [NI], oe_v [NI], wen_v [NI], cs_v [NI], ub_v [NI], lb_v [NI];
    logic          adv_v [NI], mclk_v [NI], cre_v [NI], dboe_v [NI];
    logic [AW-2:0] adr_v [NI];
    logic [15:0]   dbo_v [NI];

    int checks = 0;
    int errors = 0;
    exp_t sb_a[$];
    int   sb_rr[$];
    int   rr_ptr;

    int we_lo, oe_lo, ub_lo, cs_lo, dboe_hi, done_at, done_at_d;
    logic [NP-1:0] done_val, done_val_d;
    logic [15:0]   db_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        psram_multiport_ctrl #(
            .NUM_PORTS   (NP),
            .ADDR_W      (AW),
            .WAIT_CYCLES ((k == 3) ? 1 : 3),
            .RECOVERY    ((k == 2) ? 0 : 1),
            .ARB_RR      ((k == 1) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset_n   (rst_n),
            .req       (req),
            .we        (we),
            .addr      (addr),
            .wdata     (wdata),
            .ack       (ack_v[k]),
            .done      (done_v[k]),
            .rdata     (rdata_v[k]),
            .busy      (busy_v[k]),
            .mem_oe_n  (oe_v[k]),
            .mem_we_n  (wen_v[k]),
            .ram_cs_n  (cs_v[k]),
            .ram_ub_n  (ub_v[k]),
            .ram_lb_n  (lb_v[k]),
            .mem_adv   (adv_v[k]),
            .mem_clk   (mclk_v[k]),
            .ram_cre   (cre_v[k]),
            .mem_adr   (adr_v[k]),
            .mem_db_o  (dbo_v[k]),
            .mem_db_oe (dboe_v[k]),
            .mem_db_i  (db_i)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [7:0] d);
        we[p]             = w;
        addr[p*AW +: AW]  = a;
        wdata[p*8 +: 8]   = d;
    endtask

    function automatic int rr_pick(input int ptr, input logic [NP-1:0] r);
        for (int k = 1; k <= NP; k++) begin
            if (r[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((busy_v[0] | busy_v[1] | busy_v[2] | busy_v[3]) && n < 30) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 30), 32'd1);
    endtask

    // Observe instance 0 (and the single-wait instance) for ncyc samples, the first being the grant cycle.
    task automatic observe(input int ncyc);
        we_lo = 0; oe_lo = 0; ub_lo = 0; cs_lo = 0; dboe_hi = 0;
        done_at = -1; done_at_d = -1; done_val = '0; done_val_d = '0; db_val = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            if (wen_v[0] === 1'b0) we_lo++;
            if (oe_v[0] === 1'b0) oe_lo++;
            if (ub_v[0] === 1'b0) ub_lo++;
            if (cs_v[0] === 1'b0) cs_lo++;
            if (dboe_v[0] === 1'b1) begin
                dboe_hi++;
                db_val = dbo_v[0];
            end
            if (done_v[0] !== '0 && done_at < 0) begin
                done_at  = c;
                done_val = done_v[0];
            end
            if (done_v[3] !== '0 && done_at_d < 0) begin
                done_at_d  = c;
                done_val_d = done_v[3];
            end
        end
    endtask

    task automatic check_done_a(input string tag);
        exp_t e;
        if (sb_a.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_a.pop_front();
            chk({tag, "_done_vec"}, 32'(done_val), 32'(3'(1) << e.port));
            chk({tag, "_done_lat"}, 32'(done_at), 32'd3);
            chk({tag, "_rdata"}, 32'(rdata_v[0]), 32'(e.data));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        db_i  = '0;
        rr_ptr = NP - 1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_v[0]), 32'd1);
        chk("rst_oe_we_ub_lb", {28'd0, oe_v[0], wen_v[0], ub_v[0], lb_v[0]}, 32'hF);
        chk("rst_db_oe", 32'(dboe_v[0]), 32'd0);
        chk("rst_ack_done", {26'd0, ack_v[0], done_v[0]}, 32'd0);
        chk("rst_rdata", 32'(rdata_v[0]), 32'd0);
        chk("rst_adr", 32'(adr_v[0]), 32'd0);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("const_adv_clk_cre", {29'd0, adv_v[0], mclk_v[0], cre_v[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy_v[0]), 32'd0);

        // Port 1 reads byte 0x000005 (odd -> low lane)
        @(negedge clk);
        set_port(1, 1'b0, 24'h000005, 8'h00);
        db_i = 16'hA55A;
        req  = 3'b010;
        sb_a.push_back('{port: 1, data: 8'h5A});
        tick();
        chk("rd_ack", 32'(ack_v[0]), 32'b010);
        chk("rd_adr", 32'(adr_v[0]), 32'h000002);
        chk("rd_ub_lb", {30'd0, ub_v[0], lb_v[0]}, 32'b10);
        chk("rd_oe_we", {30'd0, oe_v[0], wen_v[0]}, 32'b01);
        chk("rd_busy", 32'(busy_v[0]), 32'd1);
        req = '0;
        rr_ptr = 1;
        observe(8);
        check_done_a("rd");
        chk("rd_cs_cycles", 32'(cs_lo), 32'd3);
        chk("rd_oe_cycles", 32'(oe_lo), 32'd3);
        chk("rd_no_db_oe", 32'(dboe_hi), 32'd0);
        chk("w1_done_lat", 32'(done_at_d), 32'd1);
        chk("w1_done_vec", 32'(done_val_d), 32'b010);
        chk("w1_rdata", 32'(rdata_v[3]), 32'h5A);

        // Port 0 writes 0xC3 to 0x000010 (even -> upper lane)
        wait_idle();
        @(negedge clk);
        set_port(0, 1'b1, 24'h000010, 8'hC3);
        db_i = 16'h0000;
        req  = 3'b001;
        sb_a.push_back('{port: 0, data: 8'h5A});
        tick();
        chk("wr_ack", 32'(ack_v[0]), 32'b001);
        chk("wr_adr", 32'(adr_v[0]), 32'h000008);
        req = '0;
        rr_ptr = 0;
        observe(8);
        check_done_a("wr");
        chk("wr_we_cycles", 32'(we_lo), 32'd3);
        chk("wr_ub_cycles", 32'(ub_lo), 32'd3);
        chk("wr_dboe_cycles", 32'(dboe_hi), 32'd3);
        chk("wr_oe_never", 32'(oe_lo), 32'd0);
        chk("wr_db_val", 32'(db_val), 32'hC3C3);
        chk("wr_dboe_after", 32'(dboe_v[0]), 32'd0);

        // Reset pulsed during the second access cycle aborts the access
        wait_idle();
        @(negedge clk);
        set_port(0, 1'b0, 24'h000021, 8'h00);
        db_i = 16'h1234;
        req  = 3'b001;
        tick();
        chk("ab_ack", 32'(ack_v[0]), 32'b001);
        req = '0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_cs_async", 32'(cs_v[0]), 32'd1);
        chk("ab_ctrl_async", {28'd0, oe_v[0], wen_v[0], ub_v[0], lb_v[0]}, 32'hF);
        chk("ab_dboe_async", 32'(dboe_v[0]), 32'd0);
        chk("ab_busy_async", 32'(busy_v[0]), 32'd0);
        rr_ptr = NP - 1;
        done_at = -1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done_v[0] !== '0 && done_at < 0) done_at = c;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done_v[0] !== '0 && done_at < 0) done_at = c;
        end
        chk("ab_no_done", 32'(done_at), 32'hFFFF_FFFF);
        chk("ab_rdata_cleared", 32'(rdata_v[0]), 32'd0);

        // First grant after reset: port 2 reads 0x000007
        @(negedge clk);
        set_port(2, 1'b0, 24'h000007, 8'h00);
        db_i = 16'hBEEF;
        req  = 3'b100;
        sb_a.push_back('{port: 2, data: 8'hEF});
        tick();
        chk("pr_ack", 32'(ack_v[0]), 32'b100);
        chk("pr_ack_rr", 32'(ack_v[1]), 32'(3'(1) << rr_pick(rr_ptr, 3'b100)));
        chk("pr_adr", 32'(adr_v[0]), 32'h000003);
        chk("pr_ub_lb", {30'd0, ub_v[0], lb_v[0]}, 32'b10);
        req = '0;
        rr_ptr = 2;
        observe(8);
        check_done_a("pr");

        // All ports request continuously: fixed, round-robin and zero-recovery spacing
        wait_idle();
        @(negedge clk);
        for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(p * 4), 8'h00);
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            rr_ptr = rr_pick(rr_ptr, 3'b111);
            sb_rr.push_back(rr_ptr);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            chk($sformatf("fx_ack_c%0d", c), 32'(ack_v[0]), (c % 5 == 0) ? 32'b001 : 32'd0);
            chk($sformatf("fx_cs_c%0d", c), 32'(cs_v[0]), (c % 5 >= 3) ? 32'd1 : 32'd0);
            if (c % 5 == 0) begin
                if (sb_rr.size() == 0)
                    chk("rr_sb_empty", 32'd0, 32'd1);
                else
                    chk($sformatf("rr_ack_c%0d", c), 32'(ack_v[1]), 32'(3'(1) << sb_rr.pop_front()));
            end else begin
                chk($sformatf("rr_ack_c%0d", c), 32'(ack_v[1]), 32'd0);
            end
            chk($sformatf("r0_ack_c%0d", c), 32'(ack_v[2]), (c % 4 == 0) ? 32'b001 : 32'd0);
            chk($sformatf("r0_cs_c%0d", c), 32'(cs_v[2]), (c % 4 == 3) ? 32'd1 : 32'd0);
        end
        req = '0;
        wait_idle();
        chk("sb_drained", 32'(sb_a.size() + sb_rr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
